// File: rtl/modexp_arbiter.sv
// Round-robin arbiter/sequencer sharing one modular-exponentiation engine
// between two requesters, with a BUSY watchdog and modulus-0 rejection.
module modexp_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] base0,
  input  logic [WIDTH-1:0] exp0,
  input  logic [WIDTH-1:0] mod0,
  input  logic [WIDTH-1:0] base1,
  input  logic [WIDTH-1:0] exp1,
  input  logic [WIDTH-1:0] mod1,
  output logic [1:0]       rsp_done,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_base,
  output logic [WIDTH-1:0] eng_exp,
  output logic [WIDTH-1:0] eng_mod,
  input  logic             eng_end,
  input  logic [WIDTH-1:0] eng_r
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WDOG_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};

  state_t           state_r;
  logic             last_grant_r;
  logic             gnt_r;
  logic [CNT_W-1:0] wdog_r;

  logic             grant_valid_s;
  logic             grant_sel_s;
  logic [WIDTH-1:0] sel_base_s;
  logic [WIDTH-1:0] sel_exp_s;
  logic [WIDTH-1:0] sel_mod_s;

  // Pick the winner: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_sel_s   = 1'b0;
    case (req)
      2'b01: begin
        grant_valid_s = 1'b1;
        grant_sel_s   = 1'b0;
      end
      2'b10: begin
        grant_valid_s = 1'b1;
        grant_sel_s   = 1'b1;
      end
      2'b11: begin
        grant_valid_s = 1'b1;
        grant_sel_s   = ~last_grant_r;
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_sel_s   = 1'b0;
      end
    endcase
    if (grant_sel_s) begin
      sel_base_s = base1;
      sel_exp_s  = exp1;
      sel_mod_s  = mod1;
    end else begin
      sel_base_s = base0;
      sel_exp_s  = exp0;
      sel_mod_s  = mod0;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      gnt_r        <= 1'b0;
      wdog_r       <= {CNT_W{1'b0}};
      rsp_done     <= 2'b00;
      rsp_data     <= ZERO_W;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
      eng_start    <= 1'b0;
      eng_base     <= ZERO_W;
      eng_exp      <= ZERO_W;
      eng_mod      <= ZERO_W;
    end else begin
      case (state_r)
        IDLE: begin
          rsp_done  <= 2'b00;
          rsp_data  <= ZERO_W;
          rsp_err   <= 1'b0;
          eng_start <= 1'b0;
          if (grant_valid_s) begin
            eng_base     <= sel_base_s;
            eng_exp      <= sel_exp_s;
            eng_mod      <= sel_mod_s;
            gnt_r        <= grant_sel_s;
            last_grant_r <= grant_sel_s;
            busy         <= 1'b1;
            // A zero modulus is answered immediately without touching the engine.
            if (sel_mod_s == ZERO_W) begin
              state_r  <= RESP;
              rsp_done <= grant_sel_s ? 2'b10 : 2'b01;
              rsp_err  <= 1'b1;
            end else begin
              state_r   <= LAUNCH;
              eng_start <= 1'b1;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        LAUNCH: begin
          eng_start <= 1'b0;
          wdog_r    <= {CNT_W{1'b0}};
          state_r   <= BUSY;
        end
        BUSY: begin
          wdog_r <= wdog_r + WDOG_ONE;
          if (eng_end) begin
            rsp_data <= eng_r;
            rsp_err  <= 1'b0;
            rsp_done <= gnt_r ? 2'b10 : 2'b01;
            state_r  <= RESP;
          end else if (wdog_r == WDOG_LAST) begin
            rsp_data <= ZERO_W;
            rsp_err  <= 1'b1;
            rsp_done <= gnt_r ? 2'b10 : 2'b01;
            state_r  <= RESP;
          end else begin
            state_r <= BUSY;
          end
        end
        RESP: begin
          rsp_done <= 2'b00;
          rsp_data <= ZERO_W;
          rsp_err  <= 1'b0;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          rsp_done  <= 2'b00;
          rsp_data  <= ZERO_W;
          rsp_err   <= 1'b0;
          busy      <= 1'b0;
          eng_start <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_arbiter.sv
// Self-checking bench for modexp_arbiter: behavioural engine model plus a
// round-robin/modexp reference model, directed and randomized jobs.
module tb_modexp_arbiter;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req;
  logic [31:0] base0, exp0, mod0, base1, exp1, mod1;
  logic [1:0]  rsp_done;
  logic [31:0] rsp_data;
  logic        rsp_err, busy, eng_start, eng_end;
  logic [31:0] eng_base, eng_exp, eng_mod, eng_r;

  int checks   = 0;
  int failures = 0;
  int model_last;
  int grant_log[$];
  logic [31:0] last_data;
  bit hang = 1'b0;
  int stray_req = 0;

  modexp_arbiter #(.WIDTH(32), .TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .req(req),
    .base0(base0), .exp0(exp0), .mod0(mod0),
    .base1(base1), .exp1(exp1), .mod1(mod1),
    .rsp_done(rsp_done), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .eng_start(eng_start), .eng_base(eng_base), .eng_exp(eng_exp), .eng_mod(eng_mod),
    .eng_end(eng_end), .eng_r(eng_r)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_modexp(input logic [31:0] b, input logic [31:0] e,
                                             input logic [31:0] m);
    logic [63:0] r, x, mm;
    if (m == 32'd0) return 32'd0;
    mm = {32'd0, m};
    r  = 64'd1 % mm;
    x  = {32'd0, b} % mm;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[31:0];
  endfunction

  // Engine model: result after a random latency; stays silent while hang is set.
  initial begin
    bit pend;
    int cnt;
    int stray_done;
    logic [31:0] res;
    pend = 1'b0; cnt = 0; stray_done = 0; res = 32'd0;
    eng_end = 1'b0; eng_r = 32'd0;
    forever begin
      @(posedge clk); #2;
      eng_end = 1'b0;
      eng_r   = $urandom;
      if (eng_start) begin
        pend = !hang;
        cnt  = $urandom_range(20, 1);
        res  = ref_modexp(eng_base, eng_exp, eng_mod);
      end else if (stray_req != stray_done) begin
        eng_end    = 1'b1;
        stray_done = stray_req;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          eng_end = 1'b1;
          eng_r   = res;
          pend    = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation bound expired");
    $fatal(1, "bound");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic rand_ops(input int who, input bit allow_zero);
    logic [31:0] m;
    m = $urandom;
    if (m == 32'd0) m = 32'd1;
    if (allow_zero && $urandom_range(4, 0) == 0) m = 32'd0;
    if (who == 0) begin base0 = $urandom; exp0 = $urandom; mod0 = m; end
    else          begin base1 = $urandom; exp1 = $urandom; mod1 = m; end
  endtask

  // Wait for one job to complete and compare it against the reference model.
  task automatic serve(input int lat0, input bit reassert);
    int who, t, ts, te, td, starts;
    logic [31:0] b, e, m, xd;
    logic xe;
    if (req == 2'b11) who = (model_last == 0) ? 1 : 0;
    else if (req[0])  who = 0;
    else              who = 1;
    model_last = who;
    grant_log.push_back(who);
    b = who ? base1 : base0;
    e = who ? exp1  : exp0;
    m = who ? mod1  : mod0;
    xe = (m == 32'd0) || hang;
    xd = xe ? 32'd0 : ref_modexp(b, e, m);
    t = 0; ts = -1; te = -1; td = -1; starts = 0;
    while (td < 0 && t < 300) begin
      tick();
      t++;
      if (eng_start) begin starts++; ts = t; end
      if (eng_end) te = t;
      if (rsp_done != 2'b00) td = t;
      else check("quiet_outputs", {31'd0, rsp_err, rsp_data}, 64'd0);
      check("busy", 64'(busy), 64'(t >= lat0));
    end
    check("done_seen", 64'(td >= 0), 64'd1);
    check("done_onehot", 64'(rsp_done), (who == 1) ? 64'd2 : 64'd1);
    check("rsp_data", 64'(rsp_data), 64'(xd));
    check("rsp_err", 64'(rsp_err), 64'(xe));
    if (m == 32'd0) begin
      check("reject_latency", 64'(td), 64'(lat0));
      check("reject_no_start", 64'(starts), 64'd0);
    end else begin
      check("start_latency", 64'(ts), 64'(lat0));
      check("start_count", 64'(starts), 64'd1);
      if (hang) check("timeout_cycles", 64'(td - ts), 64'(TMO + 1));
      else      check("end_to_done", 64'(td - te), 64'd1);
    end
    last_data = rsp_data;
    if (reassert) rand_ops(who, 1'b0);
    else req[who] = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req  = 2'b00;
    tick(); tick();
    rstn = 1'b1;
    model_last = 1;
  endtask

  initial begin
    int idx;
    bit first;
    rstn = 1'b0; req = 2'b00;
    base0 = 32'd0; exp0 = 32'd0; mod0 = 32'd0;
    base1 = 32'd0; exp1 = 32'd0; mod1 = 32'd0;
    model_last = 1;
    last_data = 32'd0;
    tick(); tick();
    check("rst_done", 64'(rsp_done), 64'd0);
    check("rst_data_err", {31'd0, rsp_err, rsp_data}, 64'd0);
    check("rst_busy_start", {busy, eng_start}, 64'd0);
    check("rst_eng_ops", {eng_base, eng_exp} | 64'(eng_mod), 64'd0);
    rstn = 1'b1;

    // Single requester, known result.
    base0 = 32'd4; exp0 = 32'd13; mod0 = 32'd497; req = 2'b01;
    serve(1, 1'b0);
    check("t1_data_445", 64'(last_data), 64'd445);
    tick();
    check("t1_busy_low", 64'(busy), 64'd0);

    // Tie from reset: requester 0 first, then requester 1.
    do_reset();
    base0 = 32'd2; exp0 = 32'd10; mod0 = 32'd1000;
    base1 = 32'd3; exp1 = 32'd5;  mod1 = 32'd7;
    req = 2'b11;
    idx = grant_log.size();
    serve(1, 1'b0);
    check("t2_first_data", 64'(last_data), 64'd24);
    check("t2_first_exp", 64'(eng_exp), 64'd10);
    serve(2, 1'b0);
    check("t2_second_data", 64'(last_data), 64'd5);
    check("t2_second_exp", 64'(eng_exp), 64'd5);
    check("t2_order0", 64'(grant_log[idx]), 64'd0);
    check("t2_order1", 64'(grant_log[idx + 1]), 64'd1);
    tick();

    // Both continuously requesting: strict alternation.
    rand_ops(0, 1'b0); rand_ops(1, 1'b0);
    req = 2'b11;
    idx = grant_log.size();
    for (int i = 0; i < 6; i++) serve((i == 0) ? 1 : 2, (i < 4) ? 1'b1 : 1'b0);
    for (int i = 0; i < 6; i++) check("fair_order", 64'(grant_log[idx + i]), 64'(i % 2));
    tick();

    // Modulus-0 reject on requester 1.
    base1 = 32'd9; exp1 = 32'd3; mod1 = 32'd0; req = 2'b10;
    serve(1, 1'b0);
    tick();

    // Randomized jobs, some with modulus 0.
    for (int j = 0; j < 20; j++) begin
      rand_ops(0, 1'b1); rand_ops(1, 1'b1);
      req = 2'($urandom_range(3, 1));
      first = 1'b1;
      while (req != 2'b00) begin
        serve(first ? 1 : 2, 1'b0);
        first = 1'b0;
      end
      tick();
    end

    // Watchdog timeout, stray eng_end in IDLE, then normal service.
    hang = 1'b1;
    rand_ops(0, 1'b0); req = 2'b01;
    serve(1, 1'b0);
    tick();
    stray_req++;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stray_no_done", {62'd0, rsp_done}, 64'd0);
      check("stray_idle", 64'(busy), 64'd0);
    end
    hang = 1'b0;
    rand_ops(0, 1'b0); req = 2'b01;
    serve(1, 1'b0);
    tick();

    // Reset during BUSY.
    hang = 1'b1;
    rand_ops(0, 1'b0); req = 2'b01;
    tick(); tick(); tick(); tick();
    check("pre_rst_busy", 64'(busy), 64'd1);
    rstn = 1'b0;
    #1;
    check("async_rst_ctrl", {59'd0, busy, eng_start, rsp_err, rsp_done}, 64'd0);
    check("async_rst_data", 64'(rsp_data), 64'd0);
    check("async_rst_ops", {eng_base, eng_exp} | 64'(eng_mod), 64'd0);
    req = 2'b00;
    tick();
    check("rst_no_done_a", 64'(rsp_done), 64'd0);
    tick();
    check("rst_no_done_b", 64'(rsp_done), 64'd0);
    rstn = 1'b1;
    model_last = 1;
    hang = 1'b0;
    rand_ops(0, 1'b0); rand_ops(1, 1'b0);
    req = 2'b11;
    idx = grant_log.size();
    serve(1, 1'b0);
    serve(2, 1'b0);
    check("post_rst_first", 64'(grant_log[idx]), 64'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
